// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// funct3 size encodings, the access-size enum and the size-to-bytes helper.
// Used by lsu_unit and lsu_store_align.
package lsu_pkg;

  localparam logic [1:0] F3_SIZE_B = 2'b00;
  localparam logic [1:0] F3_SIZE_H = 2'b01;
  localparam logic [1:0] F3_SIZE_W = 2'b10;
  localparam logic [1:0] F3_SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    SZ_B = F3_SIZE_B,
    SZ_H = F3_SIZE_H,
    SZ_W = F3_SIZE_W,
    SZ_D = F3_SIZE_D
  } access_size_e;

  function automatic logic [3:0] size_bytes(input access_size_e sz);
    logic [3:0] nb;
    nb = 4'd1;
    case (sz)
      SZ_B:    nb = 4'd1;
      SZ_H:    nb = 4'd2;
      SZ_W:    nb = 4'd4;
      SZ_D:    nb = 4'd8;
      default: nb = 4'd1;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Store lane alignment: builds the byte-enable mask and lane-positioned write data.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: size (access size), offset (byte lane of addr), store_data in;
//        mask (BYTES), data (N) out. Data above the access size is zeroed before shifting.
module lsu_store_align
  import lsu_pkg::*;
#(
  parameter int N     = 64,
  parameter int BYTES = N / 8,
  parameter int OFFW  = $clog2(BYTES)
) (
  input  access_size_e     size,
  input  logic [OFFW-1:0]  offset,
  input  logic [N-1:0]     store_data,
  output logic [BYTES-1:0] mask,
  output logic [N-1:0]     data
);

  logic [BYTES-1:0] base_mask;
  logic [N-1:0]     trunc_data;
  int               nb;

  always_comb begin
    base_mask  = '0;
    trunc_data = '0;
    nb         = int'(size_bytes(size));
    for (int i = 0; i < BYTES; i++) begin
      base_mask[i]      = (i < nb);
      trunc_data[8*i+:8] = base_mask[i] ? store_data[8*i+:8] : 8'h00;
    end
  end

  assign mask = base_mask << offset;
  assign data = trunc_data << {offset, 3'b000};

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit front end: access checks, store lane steering, exception capture.
// Latency: mem_*/writeEnable/exc_* combinational (zero cycle); cap_* registered one edge.
// Backpressure: none; requests are evaluated every cycle they are presented.
// Ports: clk, rst (sync, active-high); load, store, funct3, addr, storeData, exc_clear in;
//        writeEnable, mem_address, mem_writeData, mem_writeMask, exc_valid/exc_StLd/exc_addr,
//        cap_valid/cap_StLd/cap_addr out.
// Optional: define LSU_MISALIGN_CNT_EN to add the 32-bit saturating misalign_cnt output.
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int N     = 64,
  parameter int BYTES = N / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             store,
  input  logic [2:0]       funct3,
  input  logic [N-1:0]     addr,
  input  logic [N-1:0]     storeData,
  input  logic             exc_clear,
  output logic             writeEnable,
  output logic [N-1:0]     mem_address,
  output logic [N-1:0]     mem_writeData,
  output logic [BYTES-1:0] mem_writeMask,
  output logic             exc_valid,
  output logic             exc_StLd,
  output logic [N-1:0]     exc_addr,
  output logic             cap_valid,
  output logic             cap_StLd,
  output logic [N-1:0]     cap_addr
`ifdef LSU_MISALIGN_CNT_EN
  ,
  output logic [31:0]      misalign_cnt
`endif
);

  localparam int OFFW     = $clog2(BYTES);
  localparam bit NO_DWORD = (N == 32);

  access_size_e     size;
  logic [OFFW-1:0]  offset;
  logic             req;
  logic             misaligned;
  logic             illegal;
  logic             store_ok;
  logic [BYTES-1:0] align_mask;
  logic [N-1:0]     align_data;

  assign size   = access_size_e'(funct3[1:0]);
  assign offset = addr[OFFW-1:0];
  assign req    = load | store;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_H:    misaligned = addr[0];
      SZ_W:    misaligned = |addr[1:0];
      SZ_D:    misaligned = |addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Stores have no unsigned variant; funct3=111 would be an unsigned doubleword load.
  assign illegal = (load & store)
                 | (store & funct3[2])
                 | (load & (funct3 == 3'b111))
                 | (NO_DWORD & (size == SZ_D));

  assign exc_valid = req & (illegal | misaligned);
  assign exc_StLd  = store;
  assign exc_addr  = addr;

  // load&&store is already illegal, so store_ok implies a pure store.
  assign store_ok = store & ~exc_valid;

  lsu_store_align #(
    .N     (N),
    .BYTES (BYTES),
    .OFFW  (OFFW)
  ) u_store_align (
    .size       (size),
    .offset     (offset),
    .store_data (storeData),
    .mask       (align_mask),
    .data       (align_data)
  );

  assign writeEnable   = store_ok;
  assign mem_address   = addr;
  assign mem_writeMask = store_ok ? align_mask : '0;
  assign mem_writeData = store_ok ? align_data : '0;

  // First exception is held; a clear arriving together with a new exception
  // releases the old one and captures the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_StLd  <= 1'b0;
      cap_addr  <= '0;
    end else if (exc_valid && (!cap_valid || exc_clear)) begin
      cap_valid <= 1'b1;
      cap_StLd  <= exc_StLd;
      cap_addr  <= exc_addr;
    end else if (exc_clear) begin
      cap_valid <= 1'b0;
    end
  end

`ifdef LSU_MISALIGN_CNT_EN
  logic misalign_only;
  assign misalign_only = req & misaligned & ~illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_cnt <= '0;
    end else if (misalign_only && (misalign_cnt != '1)) begin
      misalign_cnt <= misalign_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized requests
// compared against a byte-arithmetic reference model (64-bit and 32-bit instances).
module tb_lsu_unit;

  logic        clk;
  logic        rst;
  logic        load;
  logic        store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] storeData;
  logic        exc_clear;

  logic        writeEnable;
  logic [63:0] mem_address;
  logic [63:0] mem_writeData;
  logic [7:0]  mem_writeMask;
  logic        exc_valid;
  logic        exc_StLd;
  logic [63:0] exc_addr;
  logic        cap_valid;
  logic        cap_StLd;
  logic [63:0] cap_addr;

  logic        w32_we;
  logic [31:0] w32_address;
  logic [31:0] w32_data;
  logic [3:0]  w32_mask;
  logic        w32_exc_valid;
  logic        w32_exc_stld;
  logic [31:0] w32_exc_addr;
  logic        w32_cap_valid;
  logic        w32_cap_stld;
  logic [31:0] w32_cap_addr;

`ifdef LSU_MISALIGN_CNT_EN
  logic [31:0] misalign_cnt;
  logic [31:0] w32_misalign_cnt;
`endif

  int vectors;
  int miscompares;

  // Reference state for the 64-bit instance.
  bit          m_cap_valid;
  bit          m_cap_stld;
  logic [63:0] m_cap_addr;
  longint unsigned m_cnt;

  lsu_unit #(.N(64)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3),
    .addr(addr), .storeData(storeData), .exc_clear(exc_clear),
    .writeEnable(writeEnable), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_writeMask(mem_writeMask),
    .exc_valid(exc_valid), .exc_StLd(exc_StLd), .exc_addr(exc_addr),
    .cap_valid(cap_valid), .cap_StLd(cap_StLd), .cap_addr(cap_addr)
`ifdef LSU_MISALIGN_CNT_EN
    , .misalign_cnt(misalign_cnt)
`endif
  );

  lsu_unit #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3),
    .addr(addr[31:0]), .storeData(storeData[31:0]), .exc_clear(exc_clear),
    .writeEnable(w32_we), .mem_address(w32_address),
    .mem_writeData(w32_data), .mem_writeMask(w32_mask),
    .exc_valid(w32_exc_valid), .exc_StLd(w32_exc_stld), .exc_addr(w32_exc_addr),
    .cap_valid(w32_cap_valid), .cap_StLd(w32_cap_stld), .cap_addr(w32_cap_addr)
`ifdef LSU_MISALIGN_CNT_EN
    , .misalign_cnt(w32_misalign_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Expected combinational behaviour from the access rules, for width n.
  function automatic void ref_comb(
    input  bit l, input bit s, input logic [2:0] f3,
    input  logic [63:0] a, input logic [63:0] sd, input int n,
    output bit exc, output bit we, output logic [7:0] mask,
    output logic [63:0] data, output bit mis_only);
    int unsigned nbytes, lanes, off;
    bit ill, mis, rq;
    logic [127:0] wide;
    logic [15:0]  wmask;
    nbytes = 1 << f3[1:0];
    lanes  = n / 8;
    off    = int'(a % lanes);
    rq     = l || s;
    ill    = (l && s) || (s && f3[2]) || (l && f3 == 3'b111) || (nbytes == 8 && n == 32);
    mis    = (a % nbytes) != 0;
    exc      = rq && (ill || mis);
    mis_only = rq && mis && !ill;
    we       = s && !exc;
    mask     = '0;
    data     = '0;
    if (we) begin
      wmask = ((16'd1 << nbytes) - 16'd1) << off;
      wide  = (128'(sd) & ((128'd1 << (8 * nbytes)) - 128'd1)) << (8 * off);
      mask  = wmask[7:0];
      data  = (n == 32) ? {32'd0, wide[31:0]} : wide[63:0];
    end
  endfunction

  task automatic drive(input bit l, input bit s, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] sd, input bit clr);
    load = l; store = s; funct3 = f3; addr = a; storeData = sd; exc_clear = clr;
    #2;
  endtask

  // Advance one edge and update the reference capture state from current inputs.
  task automatic tick();
    bit e, w, mo;
    logic [7:0]  mk;
    logic [63:0] dt;
    ref_comb(load, store, funct3, addr, storeData, 64, e, w, mk, dt, mo);
    @(posedge clk);
    if (rst) begin
      m_cap_valid = 0; m_cap_stld = 0; m_cap_addr = '0; m_cnt = 0;
    end else begin
      if (e && (!m_cap_valid || exc_clear)) begin
        m_cap_valid = 1; m_cap_stld = store; m_cap_addr = addr;
      end else if (exc_clear) begin
        m_cap_valid = 0;
      end
      if (mo && m_cnt != 64'hFFFF_FFFF) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, 0, 3'b000, 64'h0, 64'h0, 0);
    tick(); tick();
    vectors++;
    if (cap_valid !== 1'b0 || cap_StLd !== 1'b0 || cap_addr !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_cap: got v=%b s=%b a=%h, expected 0 0 0", cap_valid, cap_StLd, cap_addr);
    end
    vectors++;
    if (writeEnable !== 1'b0 || mem_writeMask !== 8'h0 || exc_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got we=%b mask=%h exc=%b, expected 0 00 0", writeEnable, mem_writeMask, exc_valid);
    end
    // Combinational path must ignore rst.
    drive(0, 1, 3'b000, 64'h1003, 64'hAA, 0);
    vectors++;
    if (writeEnable !== 1'b1 || mem_writeMask !== 8'h08) begin
      miscompares++;
      $display("FAIL reset_comb: got we=%b mask=%h, expected 1 08", writeEnable, mem_writeMask);
    end
`ifdef LSU_MISALIGN_CNT_EN
    vectors++;
    if (misalign_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d, expected 0", misalign_cnt);
    end
`endif
    rst = 0;
    drive(0, 0, 3'b000, 64'h0, 64'h0, 0);
    tick();
  endtask

  task automatic test_directed_stores();
    drive(0, 1, 3'b000, 64'h1003, 64'hAA, 0);
    vectors++;
    if (writeEnable !== 1'b1 || mem_writeMask !== 8'h08 || mem_writeData !== 64'hAA00_0000 ||
        exc_valid !== 1'b0 || mem_address !== 64'h1003) begin
      miscompares++;
      $display("FAIL sb_1003: got we=%b mask=%h data=%h exc=%b addr=%h, expected 1 08 aa000000 0 1003",
               writeEnable, mem_writeMask, mem_writeData, exc_valid, mem_address);
    end
    drive(0, 1, 3'b010, 64'h3004, 64'hDEAD_BEEF, 0);
    vectors++;
    if (mem_writeMask !== 8'hF0 || mem_writeData !== 64'hDEAD_BEEF_0000_0000) begin
      miscompares++;
      $display("FAIL sw_3004: got mask=%h data=%h, expected f0 deadbeef00000000", mem_writeMask, mem_writeData);
    end
    drive(0, 1, 3'b011, 64'h4000, 64'h0123_4567_89AB_CDEF, 0);
    vectors++;
    if (mem_writeMask !== 8'hFF || mem_writeData !== 64'h0123_4567_89AB_CDEF) begin
      miscompares++;
      $display("FAIL sd_4000: got mask=%h data=%h, expected ff 0123456789abcdef", mem_writeMask, mem_writeData);
    end
    drive(0, 1, 3'b001, 64'h5001, 64'hFFFF, 0);
    vectors++;
    if (exc_valid !== 1'b1 || exc_StLd !== 1'b1 || exc_addr !== 64'h5001 ||
        writeEnable !== 1'b0 || mem_writeMask !== 8'h0 || mem_writeData !== 64'h0) begin
      miscompares++;
      $display("FAIL sh_5001: got exc=%b stld=%b eaddr=%h we=%b mask=%h data=%h, expected 1 1 5001 0 00 0",
               exc_valid, exc_StLd, exc_addr, writeEnable, mem_writeMask, mem_writeData);
    end
  endtask

  task automatic test_directed_loads();
    drive(1, 0, 3'b110, 64'h6004, 64'hFFFF_FFFF, 0);
    vectors++;
    if (exc_valid !== 1'b0 || writeEnable !== 1'b0 || mem_writeMask !== 8'h0) begin
      miscompares++;
      $display("FAIL lwu_6004: got exc=%b we=%b mask=%h, expected 0 0 00", exc_valid, writeEnable, mem_writeMask);
    end
    drive(1, 0, 3'b011, 64'h8004, 64'h0, 0);
    vectors++;
    if (exc_valid !== 1'b1 || exc_StLd !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_8004: got exc=%b stld=%b, expected 1 0", exc_valid, exc_StLd);
    end
    drive(1, 0, 3'b111, 64'h9000, 64'h0, 0);
    vectors++;
    if (exc_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ld_f3_111: got exc=%b, expected 1", exc_valid);
    end
    drive(0, 1, 3'b100, 64'h9000, 64'h0, 0);
    vectors++;
    if (exc_valid !== 1'b1 || writeEnable !== 1'b0) begin
      miscompares++;
      $display("FAIL st_unsigned: got exc=%b we=%b, expected 1 0", exc_valid, writeEnable);
    end
  endtask

  task automatic test_capture();
    drive(1, 1, 3'b010, 64'h1000, 64'h0, 0);
    vectors++;
    if (exc_valid !== 1'b1 || exc_StLd !== 1'b1) begin
      miscompares++;
      $display("FAIL ld_and_st: got exc=%b stld=%b, expected 1 1", exc_valid, exc_StLd);
    end
    tick();
    vectors++;
    if (cap_valid !== 1'b1 || cap_StLd !== 1'b1 || cap_addr !== 64'h1000) begin
      miscompares++;
      $display("FAIL cap_first: got v=%b s=%b a=%h, expected 1 1 1000", cap_valid, cap_StLd, cap_addr);
    end
    drive(1, 0, 3'b011, 64'h8004, 64'h0, 0);
    tick();
    vectors++;
    if (cap_valid !== 1'b1 || cap_StLd !== 1'b1 || cap_addr !== 64'h1000) begin
      miscompares++;
      $display("FAIL cap_hold: got v=%b s=%b a=%h, expected 1 1 1000", cap_valid, cap_StLd, cap_addr);
    end
    drive(0, 0, 3'b000, 64'h0, 64'h0, 1);
    tick();
    vectors++;
    if (cap_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL cap_clear: got v=%b, expected 0", cap_valid);
    end
    // Clear and a fresh exception on the same edge: the exception is captured.
    drive(1, 0, 3'b001, 64'h2001, 64'h0, 1);
    tick();
    vectors++;
    if (cap_valid !== 1'b1 || cap_StLd !== 1'b0 || cap_addr !== 64'h2001) begin
      miscompares++;
      $display("FAIL cap_clear_vs_exc: got v=%b s=%b a=%h, expected 1 0 2001", cap_valid, cap_StLd, cap_addr);
    end
    rst = 1;
    drive(0, 1, 3'b001, 64'h3001, 64'h0, 0);
    tick();
    rst = 0;
    vectors++;
    if (cap_valid !== 1'b0 || cap_StLd !== 1'b0 || cap_addr !== 64'h0) begin
      miscompares++;
      $display("FAIL cap_rst_priority: got v=%b s=%b a=%h, expected 0 0 0", cap_valid, cap_StLd, cap_addr);
    end
`ifdef LSU_MISALIGN_CNT_EN
    drive(1, 0, 3'b010, 64'h0002, 64'h0, 0); tick();
    drive(0, 1, 3'b011, 64'h0004, 64'h0, 0); tick();
    drive(1, 1, 3'b001, 64'h0001, 64'h0, 0); tick();
    vectors++;
    if (misalign_cnt !== 32'd2) begin
      miscompares++;
      $display("FAIL cnt_misalign: got %0d, expected 2", misalign_cnt);
    end
`endif
  endtask

  task automatic test_n32();
    drive(0, 1, 3'b011, 64'h4000, 64'h1234, 0);
    vectors++;
    if (w32_exc_valid !== 1'b1 || w32_we !== 1'b0 || w32_mask !== 4'h0) begin
      miscompares++;
      $display("FAIL n32_sd: got exc=%b we=%b mask=%h, expected 1 0 0", w32_exc_valid, w32_we, w32_mask);
    end
    drive(0, 1, 3'b001, 64'h0002, 64'hBEEF, 0);
    vectors++;
    if (w32_we !== 1'b1 || w32_mask !== 4'hC || w32_data !== 32'hBEEF_0000) begin
      miscompares++;
      $display("FAIL n32_sh: got we=%b mask=%h data=%h, expected 1 c beef0000", w32_we, w32_mask, w32_data);
    end
  endtask

  task automatic test_random();
    bit e, w, mo;
    logic [7:0]  mk;
    logic [63:0] dt;
    bit l, s;
    logic [63:0] a;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0:       begin l = 0; s = 0; end
        1:       begin l = 1; s = 1; end
        2, 3, 4: begin l = 1; s = 0; end
        default: begin l = 0; s = 1; end
      endcase
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
      rst = ($urandom_range(0, 49) == 0);
      drive(l, s, 3'($urandom_range(0, 7)), a, {$urandom, $urandom}, $urandom_range(0, 3) == 0);

      ref_comb(load, store, funct3, addr, storeData, 64, e, w, mk, dt, mo);
      vectors++;
      if (exc_valid !== e || exc_StLd !== store || exc_addr !== addr || writeEnable !== w ||
          mem_writeMask !== mk || mem_writeData !== dt || mem_address !== addr) begin
        miscompares++;
        $display("FAIL rnd64 it=%0d f3=%b l=%b s=%b a=%h: got exc=%b we=%b mask=%h data=%h, expected exc=%b we=%b mask=%h data=%h",
                 it, funct3, load, store, addr, exc_valid, writeEnable, mem_writeMask, mem_writeData, e, w, mk, dt);
      end
      ref_comb(load, store, funct3, {32'd0, addr[31:0]}, storeData, 32, e, w, mk, dt, mo);
      vectors++;
      if (w32_exc_valid !== e || w32_we !== w || w32_mask !== mk[3:0] || w32_data !== dt[31:0] ||
          w32_address !== addr[31:0]) begin
        miscompares++;
        $display("FAIL rnd32 it=%0d f3=%b l=%b s=%b a=%h: got exc=%b we=%b mask=%h data=%h, expected exc=%b we=%b mask=%h data=%h",
                 it, funct3, load, store, addr[31:0], w32_exc_valid, w32_we, w32_mask, w32_data, e, w, mk[3:0], dt[31:0]);
      end

      tick();
      vectors++;
      if (cap_valid !== m_cap_valid || cap_StLd !== m_cap_stld || cap_addr !== m_cap_addr) begin
        miscompares++;
        $display("FAIL rnd_cap it=%0d: got v=%b s=%b a=%h, expected v=%b s=%b a=%h",
                 it, cap_valid, cap_StLd, cap_addr, m_cap_valid, m_cap_stld, m_cap_addr);
      end
`ifdef LSU_MISALIGN_CNT_EN
      vectors++;
      if (misalign_cnt !== 32'(m_cnt)) begin
        miscompares++;
        $display("FAIL rnd_cnt it=%0d: got %0d, expected %0d", it, misalign_cnt, m_cnt);
      end
`endif
    end
    rst = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_cap_valid = 0; m_cap_stld = 0; m_cap_addr = '0; m_cnt = 0;
    rst = 1; load = 0; store = 0; funct3 = '0; addr = '0; storeData = '0; exc_clear = 0;
    @(negedge clk);
    test_reset();
    test_directed_stores();
    test_directed_loads();
    test_capture();
    test_n32();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
